instr_fetch: RTL and testbench

Instruction fetch stage for the 64-bit RISC-V core. It holds the program counter and issues doubleword-aligned reads on the instruction port of the CPU bus arbiter. It buffers the returned 64-bit line and hands 32-bit instructions to decode over a valid/accept handshake. It stalls while the data port owns the bus, and it flushes on branch redirect.

---
 rtl/instr_fetch.sv | 81 ++++++++
 tb/tb_instr_fetch.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Instruction fetch stage for the 64-bit RISC-V core. Holds the PC, issues
// doubleword-aligned reads on the arbiter instruction port, buffers the
// returned 64-bit line and presents one 32-bit word at a time to decode.
//
// Ports:
//   clk                  clock, rising edge
//   reset                asynchronous, active-high reset
//   instr_address_out    read address, {pc[63:3],3'b000}
//   instr_read_out       read request (FETCH state, low while in reset)
//   instr_read_value_in  returned line, word0 = [31:0]
//   instr_ready_in       grant, data valid in the same cycle
//   instr_out            instruction presented to decode
//   pc_out               PC of instr_out
//   instr_valid_out      instr_out/pc_out valid (HOLD state)
//   instr_accept_in      decode consumes the instruction this cycle
//   branch_taken_in      redirect request, highest priority
//   branch_target_in     redirect target, bits [1:0] ignored
// ---------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] instr_address_out,
  output logic        instr_read_out,
  input  logic [63:0] instr_read_value_in,
  input  logic        instr_ready_in,
  output logic [31:0] instr_out,
  output logic [63:0] pc_out,
  output logic        instr_valid_out,
  input  logic        instr_accept_in,
  input  logic        branch_taken_in,
  input  logic [63:0] branch_target_in
);

  localparam logic [0:0]  S_FETCH = 1'b0;
  localparam logic [0:0]  S_HOLD  = 1'b1;
  localparam logic [63:0] PC_INIT = RESET_PC & ~64'd3;

  logic [63:0] r_pc;
  logic [63:0] r_line;
  logic [0:0]  r_state;

  logic [63:0] w_target;
  logic        w_grant;
  logic        w_accept;

  assign w_target = branch_target_in & ~64'd3;
  assign w_grant  = (r_state == S_FETCH) & instr_ready_in;
  assign w_accept = (r_state == S_HOLD) & instr_accept_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc    <= PC_INIT;
      r_line  <= 64'd0;
      r_state <= S_FETCH;
    end else if (branch_taken_in) begin
      // Redirect wins: any same-cycle grant data or accept is dropped, and
      // the target doubleword is always refetched even if already held.
      r_pc    <= w_target;
      r_state <= S_FETCH;
    end else if (w_grant) begin
      r_line  <= instr_read_value_in;
      r_state <= S_HOLD;
    end else if (w_accept) begin
      r_pc <= r_pc + 64'd4;
      // Leaving the upper word exhausts the line; lower word falls through
      // to the upper word of the same line with no bus access.
      if (r_pc[2]) r_state <= S_FETCH;
    end
  end

  assign instr_address_out = {r_pc[63:3], 3'b000};
  assign instr_read_out    = ~reset & (r_state == S_FETCH);
  assign instr_valid_out   = (r_state == S_HOLD);
  assign instr_out         = r_pc[2] ? r_line[63:32] : r_line[31:0];
  assign pc_out            = r_pc;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] instr_address_out;
  logic        instr_read_out;
  logic [63:0] instr_read_value_in;
  logic        instr_ready_in;
  logic [31:0] instr_out;
  logic [63:0] pc_out;
  logic        instr_valid_out;
  logic        instr_accept_in;
  logic        branch_taken_in;
  logic [63:0] branch_target_in;

  instr_fetch #(.RESET_PC(64'h1000)) dut (
    .clk                 (clk),
    .reset               (reset),
    .instr_address_out   (instr_address_out),
    .instr_read_out      (instr_read_out),
    .instr_read_value_in (instr_read_value_in),
    .instr_ready_in      (instr_ready_in),
    .instr_out           (instr_out),
    .pc_out              (pc_out),
    .instr_valid_out     (instr_valid_out),
    .instr_accept_in     (instr_accept_in),
    .branch_taken_in     (branch_taken_in),
    .branch_target_in    (branch_target_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic [63:0] data;
    logic        acc;
    logic        br;
    logic [63:0] tgt;
    logic        e_rd;
    logic [63:0] e_addr;
    logic        e_vld;
    logic [31:0] e_ins;
    logic [63:0] e_pc;
  } vec_t;

  typedef struct {
    logic [31:0] ins;
    logic [63:0] pc;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];
  int   nvec = 0;
  int   nmis = 0;

  function automatic vec_t mk(logic rdy, logic [63:0] data, logic acc, logic br,
                              logic [63:0] tgt, logic e_rd, logic [63:0] e_addr,
                              logic e_vld, logic [31:0] e_ins, logic [63:0] e_pc);
    vec_t v;
    v.rdy = rdy; v.data = data; v.acc = acc; v.br = br; v.tgt = tgt;
    v.e_rd = e_rd; v.e_addr = e_addr; v.e_vld = e_vld; v.e_ins = e_ins; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic chk(string nm, logic e_rd, logic [63:0] e_addr, logic e_vld,
                     logic chk_ins, logic [31:0] e_ins, logic [63:0] e_pc);
    nvec++;
    if (instr_read_out !== e_rd || instr_address_out !== e_addr ||
        instr_valid_out !== e_vld || pc_out !== e_pc ||
        (chk_ins && instr_out !== e_ins)) begin
      nmis++;
      $display("FAIL %s: got rd=%0b addr=%h vld=%0b ins=%h pc=%h, want rd=%0b addr=%h vld=%0b ins=%h pc=%h",
               nm, instr_read_out, instr_address_out, instr_valid_out, instr_out, pc_out,
               e_rd, e_addr, e_vld, e_ins, e_pc);
    end
  endtask

  task automatic drive(logic rdy, logic [63:0] data, logic acc, logic br, logic [63:0] tgt);
    instr_ready_in      = rdy;
    instr_read_value_in = data;
    instr_accept_in     = acc;
    branch_taken_in     = br;
    branch_target_in    = tgt;
  endtask

  initial begin
    int grants;
    int pops;
    // Directed vectors: inputs held for one clock, outputs checked 1ns after the edge.
    vt.push_back(mk(1, 64'hAAAAAAAA_55555555, 0, 0, 0, 0, 64'h1000, 1, 32'h55555555, 64'h1000));
    vt.push_back(mk(0, 0, 1, 0, 0, 0, 64'h1000, 1, 32'hAAAAAAAA, 64'h1004));
    vt.push_back(mk(0, 0, 1, 0, 0, 1, 64'h1008, 0, 0, 64'h1008));
    vt.push_back(mk(0, 0, 0, 0, 0, 1, 64'h1008, 0, 0, 64'h1008));
    vt.push_back(mk(0, 0, 0, 0, 0, 1, 64'h1008, 0, 0, 64'h1008));
    vt.push_back(mk(0, 0, 0, 0, 0, 1, 64'h1008, 0, 0, 64'h1008));
    vt.push_back(mk(1, 64'h11111111_22222222, 0, 0, 0, 0, 64'h1008, 1, 32'h22222222, 64'h1008));
    for (int i = 0; i < 5; i++)
      vt.push_back(mk(1, 64'hBAD0BAD0_BAD0BAD0, 0, 0, 0, 0, 64'h1008, 1, 32'h22222222, 64'h1008));
    vt.push_back(mk(0, 0, 1, 0, 0, 0, 64'h1008, 1, 32'h11111111, 64'h100C));
    // redirect together with accept: pc takes the target, not pc+4
    vt.push_back(mk(0, 0, 1, 1, 64'h300, 1, 64'h300, 0, 0, 64'h300));
    // redirect together with grant: line discarded, target bits [1:0] dropped
    vt.push_back(mk(1, 64'hDEADBEEF_CAFEF00D, 0, 1, 64'h200E, 1, 64'h2008, 0, 0, 64'h200C));
    vt.push_back(mk(1, 64'h33333333_44444444, 0, 0, 0, 0, 64'h2008, 1, 32'h33333333, 64'h200C));
    vt.push_back(mk(0, 0, 1, 0, 0, 1, 64'h2010, 0, 0, 64'h2010));
    // pc wraps modulo 2^64
    vt.push_back(mk(0, 0, 0, 1, 64'hFFFFFFFF_FFFFFFFF, 1, 64'hFFFFFFFF_FFFFFFF8, 0, 0, 64'hFFFFFFFF_FFFFFFFC));
    vt.push_back(mk(1, 64'h77777777_66666666, 0, 0, 0, 0, 64'hFFFFFFFF_FFFFFFF8, 1, 32'h77777777, 64'hFFFFFFFF_FFFFFFFC));
    vt.push_back(mk(0, 0, 1, 0, 0, 1, 64'h0, 0, 0, 64'h0));
    vt.push_back(mk(0, 0, 0, 0, 0, 1, 64'h0, 0, 0, 64'h0));

    drive(0, 0, 0, 0, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("in_reset", 0, 64'h1000, 0, 1, 32'h0, 64'h1000);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_reset", 1, 64'h1000, 0, 0, 0, 64'h1000);
    @(posedge clk); #1;
    chk("first_cycle", 1, 64'h1000, 0, 0, 0, 64'h1000);

    foreach (vt[i]) begin
      drive(vt[i].rdy, vt[i].data, vt[i].acc, vt[i].br, vt[i].tgt);
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), vt[i].e_rd, vt[i].e_addr, vt[i].e_vld, vt[i].e_vld,
          vt[i].e_ins, vt[i].e_pc);
    end

    // Reset mid-cycle during a stalled fetch: the old line must not reappear.
    drive(0, 0, 0, 0, 0);
    #3 reset = 1'b1;
    #1 chk("reset_midfetch", 0, 64'h1000, 0, 1, 32'h0, 64'h1000);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("reset_release", 1, 64'h1000, 0, 0, 0, 64'h1000);
    @(posedge clk); #1;
    chk("reset_stall", 1, 64'h1000, 0, 1, 32'h0, 64'h1000);

    // Random grant/accept traffic against a scoreboard of presented words.
    grants = 0;
    pops = 0;
    for (int c = 0; c < 400; c++) begin
      logic        rdy;
      logic        acc;
      logic [63:0] d;
      exp_t        e;
      rdy = ($urandom_range(0, 2) != 0);
      acc = ($urandom_range(0, 2) != 0);
      d   = {$urandom(), $urandom()};
      if (instr_read_out && rdy) begin
        e.ins = d[31:0];  e.pc = instr_address_out;          sb.push_back(e);
        e.ins = d[63:32]; e.pc = instr_address_out + 64'd4;  sb.push_back(e);
        grants++;
      end
      if (instr_valid_out && acc) begin
        nvec++;
        pops++;
        if (sb.size() == 0) begin
          nmis++;
          $display("FAIL sb_empty: got ins=%h pc=%h, want no valid instruction", instr_out, pc_out);
        end else begin
          e = sb.pop_front();
          if (instr_out !== e.ins || pc_out !== e.pc) begin
            nmis++;
            $display("FAIL sb_word: got ins=%h pc=%h, want ins=%h pc=%h",
                     instr_out, pc_out, e.ins, e.pc);
          end
        end
      end
      drive(rdy, d, acc, 0, 0);
      @(posedge clk); #1;
    end
    nvec++;
    if (pops < 50 || sb.size() > 2) begin
      nmis++;
      $display("FAIL sb_progress: got pops=%0d grants=%0d left=%0d, want pops>=50 left<=2",
               pops, grants, sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
